// File: rtl/aes_gcm_encrypt_stream.sv
// Streaming 32-bit word encryptor with simplified keystream/GHASH and 128-bit auth tag.
// Optional: define AES_GCM_ENC_LEN_IN_TAG_EN to fold the message length into the tag.
module aes_gcm_encrypt_stream #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [255:0]     key,
    input  logic [255:0]     iv,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [31:0]      plaintext,
    input  logic             plaintext_valid,
    output logic             plaintext_ready,
    output logic [31:0]      ciphertext,
    output logic             ciphertext_valid,
    input  logic             ciphertext_ready,
    output logic [127:0]     auth_tag,
    output logic             tag_valid,
    output logic             busy,
    output logic             complete
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_FINAL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       iv_q, iv_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   n_q, n_d;
    logic [127:0]       acc_q, acc_d;
    logic [31:0]        ct_q, ct_d;
    logic               ct_vld_q, ct_vld_d;
    logic [127:0]       tag_q, tag_d;
    logic               tag_vld_q, tag_vld_d;
    logic               complete_q, complete_d;
`ifdef AES_GCM_ENC_LEN_IN_TAG_EN
    logic               len_folded_q, len_folded_d;
`endif

    logic               accept;
    logic               out_free;
    logic [31:0]        ct_next;

    // Only the low 128 bits of key/IV feed the simplified cipher.
    logic unused_key_iv_hi;
    assign unused_key_iv_hi = ^{key[255:128], iv[255:128]};

    // A single output register: a word may enter whenever the held word leaves this cycle.
    assign out_free        = !ct_vld_q || ciphertext_ready;
    assign plaintext_ready = (state_q == S_STREAM) && out_free;
    assign accept          = plaintext_ready && plaintext_valid;
    assign ct_next         = plaintext ^ key_q[31:0] ^ iv_q[31:0] ^ 32'(n_q);

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        iv_d       = iv_q;
        len_d      = len_q;
        n_d        = n_q;
        acc_d      = acc_q;
        ct_d       = ct_q;
        ct_vld_d   = ct_vld_q;
        tag_d      = tag_q;
        tag_vld_d  = tag_vld_q;
        complete_d = 1'b0;
`ifdef AES_GCM_ENC_LEN_IN_TAG_EN
        len_folded_d = len_folded_q;
`endif

        if (ct_vld_q && ciphertext_ready) begin
            ct_vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    key_d     = key[127:0];
                    iv_d      = iv[127:0];
                    len_d     = msg_len;
                    n_d       = LEN_W'(1);
                    acc_d     = '0;
                    tag_d     = '0;
                    tag_vld_d = 1'b0;
                    state_d   = S_LOAD;
`ifdef AES_GCM_ENC_LEN_IN_TAG_EN
                    len_folded_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                state_d = (len_q != '0) ? S_STREAM : S_FINAL;
            end
            S_STREAM: begin
                if (accept) begin
                    ct_d     = ct_next;
                    ct_vld_d = 1'b1;
                    acc_d    = {acc_q[95:0], acc_q[127:96] ^ ct_next};
                    // Stop counting at the last word so n never wraps at the max length.
                    if (n_q == len_q) begin
                        state_d = S_FINAL;
                    end else begin
                        n_d = n_q + LEN_W'(1);
                    end
                end
            end
            S_FINAL: begin
`ifdef AES_GCM_ENC_LEN_IN_TAG_EN
                if (!len_folded_q) begin
                    acc_d        = {acc_q[95:0], acc_q[127:96] ^ 32'(len_q)};
                    len_folded_d = 1'b1;
                end else if (out_free) begin
                    tag_d      = acc_q ^ key_q ^ iv_q;
                    tag_vld_d  = 1'b1;
                    complete_d = 1'b1;
                    state_d    = S_DONE;
                end
`else
                if (out_free) begin
                    tag_d      = acc_q ^ key_q ^ iv_q;
                    tag_vld_d  = 1'b1;
                    complete_d = 1'b1;
                    state_d    = S_DONE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            iv_q       <= '0;
            len_q      <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            ct_q       <= '0;
            ct_vld_q   <= 1'b0;
            tag_q      <= '0;
            tag_vld_q  <= 1'b0;
            complete_q <= 1'b0;
`ifdef AES_GCM_ENC_LEN_IN_TAG_EN
            len_folded_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            iv_q       <= iv_d;
            len_q      <= len_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            ct_q       <= ct_d;
            ct_vld_q   <= ct_vld_d;
            tag_q      <= tag_d;
            tag_vld_q  <= tag_vld_d;
            complete_q <= complete_d;
`ifdef AES_GCM_ENC_LEN_IN_TAG_EN
            len_folded_q <= len_folded_d;
`endif
        end
    end

    assign ciphertext       = ct_q;
    assign ciphertext_valid = ct_vld_q;
    assign auth_tag         = tag_q;
    assign tag_valid        = tag_vld_q;
    assign complete         = complete_q;
    assign busy             = (state_q == S_LOAD) || (state_q == S_STREAM) || (state_q == S_FINAL);

endmodule
